mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single-ported memory access unit between the instruction-fetch requester and the load/store requester. Each requester has a valid/ready request channel and a valid/ready response channel. The block latches the winning request, drives the memory unit's one-cycle-latency interface, captures the registered read data and fault flags, and returns them to the requester that won. It sits between the core's fetch/execute stages and the memory unit.

Parameters:
ARB_MODE, 0, 0 = round-robin between fetch and data when both request; 1 = data port always wins.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
if_req_valid  input  1  fetch request valid
if_req_ready  output  1  fetch request accepted this cycle
if_addr  input  32  fetch address (word read)
if_rsp_valid  output  1  fetch response valid
if_rsp_ready  input  1  fetch response consumed
if_rsp_data  output  32  fetched word
if_rsp_fault  output  3  {op_fault, addr_fault, access_fault}
d_req_valid  input  1  data request valid
d_req_ready  output  1  data request accepted this cycle
d_is_write  input  1  store (1) / load (0)
d_is_unsigned  input  1  zero-extend sub-word load
d_op  input  2  00 = byte, 01 = half-word, 10 = word, 11 = invalid
d_addr  input  32  data address
d_wdata  input  32  store data
d_rsp_valid  output  1  data response valid
d_rsp_ready  input  1  data response consumed
d_rsp_data  output  32  load result (undefined for stores)
d_rsp_fault  output  3  {op_fault, addr_fault, access_fault}
mem_available  output  1  to memory unit: operation available
mem_is_write  output  1  to memory unit
mem_is_unsigned  output  1  to memory unit
mem_op  output  2  to memory unit
mem_addr  output  32  to memory unit
mem_in  output  32  to memory unit
mem_out  input  32  from memory unit, registered
mem_op_fault  input  1  from memory unit
mem_addr_fault  input  1  from memory unit
mem_access_fault  input  1  from memory unit

Behaviour:
- FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE. Exactly one operation is in flight; there is no pipelining.
- IDLE
  - A request is accepted on the same cycle it is presented. Only the winner's req_ready is 1; all req_ready are 0 in every other state.
  - Fetch requests are latched as op=10, is_write=0, is_unsigned=0, in=0.
  - The grant owner is latched, and the FSM moves to ISSUE.
- ISSUE: mem_available=1 for exactly one cycle. The mem_* outputs come from the latch and are stable for the whole cycle. Next state is CAPTURE.
- CAPTURE: mem_available=0. mem_out and the three fault inputs are registered into the response buffer. Next state is RESP.
- RESP
  - The owner's rsp_valid=1; the other port's rsp_valid stays 0.
  - data and fault outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid & rsp_ready, the FSM returns to IDLE.
  - A new request is accepted no earlier than the following cycle, so the minimum spacing between requests is 4 cycles.
- Latency: request accepted in cycle N, rsp_valid first high in cycle N+3.
- Arbitration, round-robin (ARB_MODE=0):
  - On contention, the port that did not win the last contended grant wins.
  - The last-winner register updates only on contended grants and resets to "fetch", so data wins the first contention.
  - A lone requester always wins.
- Arbitration, fixed (ARB_MODE=1): data wins on contention; fetch can starve.
- Faults are passed through unmodified. A request with a fault still completes through all four states and returns a response.
- Outside ISSUE, the mem_* outputs hold their latched values.
- Reset (asserted asynchronously, including mid-operation):
  - FSM returns to IDLE.
  - mem_available=0; all req_ready and rsp_valid are 0.
  - Latch, response data and rsp_fault are cleared to 0; round-robin state is set to "fetch".
  - Any in-flight operation is discarded.
  - The memory unit resets synchronously, so no op is issued until reset_n has been high for at least one clk edge.

Test Plan:
- Fetch-only, if_addr=0x100, memory returns 0xDEADBEEF -> mem_available high in cycle N+1 only, with op=10; if_rsp_valid in cycle N+3 with data 0xDEADBEEF and fault 000.
- Both ports request in the same cycle, repeated 4 times with ARB_MODE=0 -> grant order data, fetch, data, fetch. With ARB_MODE=1 -> data wins all four.
- Data half-word load at d_addr=0x101 -> d_rsp_fault=010. Data op=11 -> d_rsp_fault has bit 2 set. Both complete with a response.
- d_rsp_ready held low for 5 cycles after d_rsp_valid -> data/fault stable, no new grant, if_req_ready stays 0; release -> IDLE on the next cycle.
- reset_n dropped asynchronously in the ISSUE state -> mem_available, rsp_valid and req_ready all 0 immediately; after release, a fresh fetch completes normally.
- Store d_op=10, d_addr=0x200, d_wdata=0x12345678 -> mem_is_write=1 and mem_in=0x12345678 during ISSUE; d_rsp_valid in cycle N+3 with fault 000.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single-ported, one-cycle-latency memory unit.
// One operation in flight at a time: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
module mem_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic [2:0]  if_rsp_fault,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_is_write,
    input  logic        d_is_unsigned,
    input  logic [1:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic [2:0]  d_rsp_fault,
    output logic        mem_available,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_op_fault,
    input  logic        mem_addr_fault,
    input  logic        mem_access_fault
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic FIXED_PRIO = (ARB_MODE == 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        en_r;          // set once reset_n has seen a clock edge
    logic        owner_d_r;     // 1 = data port owns the in-flight op
    logic        last_d_r;      // winner of the last contended grant, 1 = data
    logic        lat_write_r;
    logic        lat_unsigned_r;
    logic [1:0]  lat_op_r;
    logic [31:0] lat_addr_r;
    logic [31:0] lat_in_r;
    logic [31:0] rsp_data_r;
    logic [2:0]  rsp_fault_r;
    logic        contend_s;
    logic        grant_d_s;
    logic        grant_if_s;
    logic        accept_s;
    logic        rsp_hs_s;

    // Arbitration: only evaluated while idle and out of reset.
    always_comb begin
        contend_s  = if_req_valid & d_req_valid;
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
        if ((state_r == ST_IDLE) && en_r) begin
            if (contend_s) begin
                if (FIXED_PRIO || !last_d_r) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_if_s = 1'b1;
                end
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
            end else if (if_req_valid) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s  = 1'b0;
                grant_if_s = 1'b0;
            end
        end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
        end
        accept_s = grant_d_s | grant_if_s;
        rsp_hs_s = owner_d_r ? d_rsp_ready : if_rsp_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = accept_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:   state_nxt_s = ST_CAPTURE;
            ST_CAPTURE: state_nxt_s = ST_RESP;
            ST_RESP:    state_nxt_s = rsp_hs_s ? ST_IDLE : ST_RESP;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs and port wiring of the latch / response buffer.
    always_comb begin
        if_req_ready    = grant_if_s;
        d_req_ready     = grant_d_s;
        mem_available   = (state_r == ST_ISSUE);
        if_rsp_valid    = (state_r == ST_RESP) && !owner_d_r;
        d_rsp_valid     = (state_r == ST_RESP) && owner_d_r;
        mem_is_write    = lat_write_r;
        mem_is_unsigned = lat_unsigned_r;
        mem_op          = lat_op_r;
        mem_addr        = lat_addr_r;
        mem_in          = lat_in_r;
        if_rsp_data     = rsp_data_r;
        if_rsp_fault    = rsp_fault_r;
        d_rsp_data      = rsp_data_r;
        d_rsp_fault     = rsp_fault_r;
    end

    // Request latch, ownership, round-robin history and response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_r           <= 1'b0;
            owner_d_r      <= 1'b0;
            last_d_r       <= 1'b0;
            lat_write_r    <= 1'b0;
            lat_unsigned_r <= 1'b0;
            lat_op_r       <= 2'b00;
            lat_addr_r     <= 32'h0000_0000;
            lat_in_r       <= 32'h0000_0000;
            rsp_data_r     <= 32'h0000_0000;
            rsp_fault_r    <= 3'b000;
        end else begin
            en_r <= 1'b1;
            if (accept_s) begin
                owner_d_r <= grant_d_s;
                if (contend_s) begin
                    last_d_r <= grant_d_s;
                end
                if (grant_d_s) begin
                    lat_write_r    <= d_is_write;
                    lat_unsigned_r <= d_is_unsigned;
                    lat_op_r       <= d_op;
                    lat_addr_r     <= d_addr;
                    lat_in_r       <= d_wdata;
                end else begin
                    lat_write_r    <= 1'b0;
                    lat_unsigned_r <= 1'b0;
                    lat_op_r       <= 2'b10;
                    lat_addr_r     <= if_addr;
                    lat_in_r       <= 32'h0000_0000;
                end
            end
            if (state_r == ST_CAPTURE) begin
                rsp_data_r  <= mem_out;
                rsp_fault_r <= {mem_op_fault, mem_addr_fault, mem_access_fault};
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random requests against a transaction-level model,
// with a round-robin (dut0) and a fixed-priority (dut1) instance driven in lock-step.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req_valid, if_rsp_ready;
    logic [31:0] if_addr;
    logic        d_req_valid, d_is_write, d_is_unsigned, d_rsp_ready;
    logic [1:0]  d_op;
    logic [31:0] d_addr, d_wdata;

    logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid;
    logic [31:0] if_rsp_data, d_rsp_data;
    logic [2:0]  if_rsp_fault, d_rsp_fault;
    logic        mem_available, mem_is_write, mem_is_unsigned;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_op_fault, mem_addr_fault, mem_access_fault;

    logic        if_req_ready1, if_rsp_valid1, d_req_ready1, d_rsp_valid1;
    logic [31:0] if_rsp_data1, d_rsp_data1;
    logic [2:0]  if_rsp_fault1, d_rsp_fault1;
    logic        mem_available1, mem_is_write1, mem_is_unsigned1;
    logic [1:0]  mem_op1;
    logic [31:0] mem_addr1, mem_in1, mem_out1;
    logic        mem_op_fault1, mem_addr_fault1, mem_access_fault1;

    int n_total = 0;
    int n_pass  = 0;
    bit data_turn;

    always #5 clk = ~clk;

    mem_arbiter #(.ARB_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_fault(if_rsp_fault),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_is_write(d_is_write),
        .d_is_unsigned(d_is_unsigned), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_fault(d_rsp_fault),
        .mem_available(mem_available), .mem_is_write(mem_is_write),
        .mem_is_unsigned(mem_is_unsigned), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out), .mem_op_fault(mem_op_fault),
        .mem_addr_fault(mem_addr_fault), .mem_access_fault(mem_access_fault)
    );

    mem_arbiter #(.ARB_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready1), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid1), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data1), .if_rsp_fault(if_rsp_fault1),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready1), .d_is_write(d_is_write),
        .d_is_unsigned(d_is_unsigned), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid1), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data1), .d_rsp_fault(d_rsp_fault1),
        .mem_available(mem_available1), .mem_is_write(mem_is_write1),
        .mem_is_unsigned(mem_is_unsigned1), .mem_op(mem_op1), .mem_addr(mem_addr1),
        .mem_in(mem_in1), .mem_out(mem_out1), .mem_op_fault(mem_op_fault1),
        .mem_addr_fault(mem_addr_fault1), .mem_access_fault(mem_access_fault1)
    );

    // Behaviour of the memory unit as seen through its interface.
    function automatic logic [31:0] rdata_of(input logic [31:0] a, input logic [1:0] op,
                                             input logic u);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a ^ 32'h5A5A_0000) + {29'd0, u, op};
    endfunction

    function automatic logic [2:0] fault_of(input logic [31:0] a, input logic [1:0] op);
        logic opf, af, acf;
        opf = (op == 2'b11);
        af  = ((op == 2'b01) && a[0]) || ((op == 2'b10) && (a[1:0] != 2'b00));
        acf = (a[31:28] == 4'hF);
        return {opf, af, acf};
    endfunction

    // One-cycle-latency memory stubs for both instances.
    always @(posedge clk) begin
        if (mem_available) begin
            mem_out <= rdata_of(mem_addr, mem_op, mem_is_unsigned);
            {mem_op_fault, mem_addr_fault, mem_access_fault} <= fault_of(mem_addr, mem_op);
        end
        if (mem_available1) begin
            mem_out1 <= rdata_of(mem_addr1, mem_op1, mem_is_unsigned1);
            {mem_op_fault1, mem_addr_fault1, mem_access_fault1} <= fault_of(mem_addr1, mem_op1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, entered and left at posedge+1 of an idle cycle.
    task automatic do_op(input bit fv, input bit dv, input logic [31:0] ia,
                         input bit dw, input bit du, input logic [1:0] dop,
                         input logic [31:0] da, input logic [31:0] dwd, input int hold);
        bit          win_d;
        logic        e_w, e_u;
        logic [1:0]  e_op;
        logic [31:0] e_addr, e_in, e_data;
        logic [2:0]  e_fault;
        if (fv && dv) begin
            win_d     = data_turn;
            data_turn = !data_turn;
        end else begin
            win_d = dv;
        end
        if (win_d) begin
            e_w = dw; e_u = du; e_op = dop; e_addr = da; e_in = dwd;
        end else begin
            e_w = 1'b0; e_u = 1'b0; e_op = 2'b10; e_addr = ia; e_in = 32'd0;
        end
        e_data  = rdata_of(e_addr, e_op, e_u);
        e_fault = fault_of(e_addr, e_op);

        // cycle N: present and accept
        if_req_valid = fv; if_addr = ia;
        d_req_valid = dv; d_is_write = dw; d_is_unsigned = du; d_op = dop;
        d_addr = da; d_wdata = dwd;
        #1;
        chk("if_req_ready", 32'(if_req_ready), 32'(fv && !win_d));
        chk("d_req_ready", 32'(d_req_ready), 32'(dv && win_d));
        chk("fixed_d_ready", 32'(d_req_ready1), 32'(dv));
        chk("fixed_if_ready", 32'(if_req_ready1), 32'(fv && !dv));
        tick();
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        // cycle N+1: ISSUE
        chk("issue_available", 32'(mem_available), 32'd1);
        chk("issue_op", 32'(mem_op), 32'(e_op));
        chk("issue_addr", mem_addr, e_addr);
        chk("issue_write", 32'(mem_is_write), 32'(e_w));
        chk("issue_unsigned", 32'(mem_is_unsigned), 32'(e_u));
        chk("issue_in", mem_in, e_in);
        tick();
        // cycle N+2: CAPTURE
        chk("capture_available", 32'(mem_available), 32'd0);
        chk("capture_rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
        chk("capture_addr_held", mem_addr, e_addr);
        if (hold > 0) begin
            if_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
        end
        tick();
        // cycle N+3 onwards: RESP
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                tick();
                if_req_valid = 1'b1; d_req_valid = 1'b1;
                #1;
                chk("hold_if_req_ready", 32'(if_req_ready), 32'd0);
                chk("hold_d_req_ready", 32'(d_req_ready), 32'd0);
                if_req_valid = 1'b0; d_req_valid = 1'b0;
            end
            chk("rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), win_d ? 32'd1 : 32'd2);
            if (!(win_d && e_w)) begin
                chk("rsp_data", win_d ? d_rsp_data : if_rsp_data, e_data);
            end
            chk("rsp_fault", 32'(win_d ? d_rsp_fault : if_rsp_fault), 32'(e_fault));
        end
        if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        tick();
        chk("back_to_idle", 32'({if_rsp_valid, d_rsp_valid, mem_available}), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        if_req_valid = 1'b0; if_addr = 32'd0; if_rsp_ready = 1'b1;
        d_req_valid = 1'b0; d_is_write = 1'b0; d_is_unsigned = 1'b0; d_op = 2'b00;
        d_addr = 32'd0; d_wdata = 32'd0; d_rsp_ready = 1'b1;
        data_turn = 1'b1;
        tick(); tick();
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        chk("reset_ready", 32'({if_req_ready, d_req_ready}), 32'd0);
        chk("reset_valid", 32'({if_rsp_valid, d_rsp_valid, mem_available}), 32'd0);
        chk("reset_latch", mem_addr, 32'd0);
        chk("reset_rsp_fault", 32'(d_rsp_fault), 32'd0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        do_op(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 1'b1, 32'h40 + 32'(i * 4), 1'b0, 1'b0, 2'b10,
                  32'h80 + 32'(i * 4), 32'd0, 0);
        end
        do_op(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 2'b01, 32'h101, 32'd0, 0);
        do_op(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 2'b11, 32'h200, 32'd0, 0);
        do_op(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 2'b00, 32'h333, 32'd0, 5);
        do_op(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 2'b10, 32'h200, 32'h1234_5678, 0);

        // asynchronous reset while an op is in ISSUE
        if_req_valid = 1'b1; if_addr = 32'h500;
        tick();
        if_req_valid = 1'b0;
        chk("pre_reset_issue", 32'(mem_available), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_available", 32'(mem_available), 32'd0);
        chk("async_rst_rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), 32'd0);
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        #1;
        chk("async_rst_ready", 32'({if_req_ready, d_req_ready}), 32'd0);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        data_turn = 1'b1;
        tick();
        chk("post_reset_idle", 32'({if_rsp_valid, d_rsp_valid, mem_available}), 32'd0);
        do_op(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 0);
        do_op(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 2'b10, 32'h108, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            bit          fv, dv;
            logic [31:0] ia, da;
            fv = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!fv && !dv) fv = 1'b1;
            ia = $urandom;
            da = $urandom;
            do_op(fv, dv, ia, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), da, $urandom, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
